mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: DW, default 8, data width of every channel.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  4  per-channel valid; bit i = channel i.
REQ-005 Port: in_data  input  4*DW  channel i data at bits [i*DW +: DW].
REQ-006 Port: in_ready  output  4  per-channel accept; bit i = channel i.
REQ-007 Port: out_valid  output  1  output register holds a word.
REQ-008 Port: out_data  output  DW  merged data word.
REQ-009 Port: out_sel  output  2  source channel index of out_data; same encoding as the 4-way demux select ({sel1,sel0}).
REQ-010 Port: out_ready  input  1  downstream accept.

Function
REQ-011 Transfer on any port SHALL occur only in a cycle where valid and ready are both 1 at the rising edge.
REQ-012 load = !out_valid || out_ready; the output register SHALL accept a new word only when load = 1.
REQ-013 Arbitration SHALL be round-robin over the 4 channels, starting the search at pointer ptr (2 bits) and ascending mod 4.
REQ-014 grant = first i in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with in_valid[i] = 1; no grant if in_valid = 0.
REQ-015 in_ready SHALL be one-hot at grant when load = 1 and a grant exists, otherwise 4'b0000; it is combinational from in_valid, ptr, out_valid and out_ready.
REQ-016 On a load with a grant: out_data <= channel grant data, out_sel <= grant, out_valid <= 1, ptr <= grant+1 mod 4 (3 wraps to 0).
REQ-017 On a load with no grant: out_valid <= 0; out_data, out_sel and ptr hold.
REQ-018 When load = 0: out_valid, out_data, out_sel and ptr SHALL hold (stall; no input accepted).
REQ-019 Latency: an input word accepted at edge N SHALL appear on out_* from after edge N until the edge where it is consumed.
REQ-020 Throughput: with out_ready held at 1 and at least one in_valid set, one word SHALL transfer per cycle (simultaneous output consume and input load).
REQ-021 Fairness: a channel holding in_valid high SHALL be granted within 4 loads.
REQ-022 Ungranted channels SHALL see in_ready = 0 and SHALL NOT lose data (sources hold valid/data until accepted).
REQ-023 in_valid changing during a stall SHALL affect only the next load, never the held output word.

Reset
REQ-024 With rst_n = 0 at a rising edge: out_valid = 0, out_data = 0, out_sel = 2'b00, ptr = 2'b00.
REQ-025 in_ready SHALL be 4'b0000 in any cycle where rst_n = 0.
REQ-026 Reset asserted mid-stall SHALL discard the held word; the first grant after release SHALL search from channel 0.

Structure
REQ-027 Shared package mux_pkg SHALL hold NCH = 4, SELW = 2, and the channel-index type.
REQ-028 One sub-module, rr_arbiter_4, SHALL be purely combinational: inputs req[3:0] and ptr, outputs grant index and grant_valid.
REQ-029 The pointer and the output register SHALL live in mux_arbiter; the design SHALL contain no latches.

Verification
REQ-030 Reset, then in_valid = 4'b1111 with data 8'hA0..A3 and out_ready = 1 -> out_sel sequence 0,1,2,3,0 and out_data A0,A1,A2,A3,A0 on consecutive cycles.
REQ-031 Only channel 2 valid (data 8'h5C), out_ready = 1 -> in_ready = 4'b0100, out_sel = 2, out_data = 8'h5C one cycle later, ptr = 3.
REQ-032 out_valid = 1 and out_ready = 0 for 3 cycles with all in_valid = 1 -> in_ready = 0 and out_data stable for 3 cycles; word accepted in the cycle out_ready rises.
REQ-033 ptr = 3, in_valid = 4'b1001 -> grant channel 3 first, then channel 0 (wrap-around).
REQ-034 rst_n = 0 during a stall holding 8'h77 -> next cycle out_valid = 0; after release, in_valid = 4'b1010 -> channel 1 granted first.
REQ-035 Loop-back: feed out_data/out_sel into the 4-way demux -> each demux output equals the corresponding source stream in order.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and types for the 4-channel round-robin merge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mux_pkg;
  localparam int NCH  = 4;
  localparam int SELW = 2;

  // Channel index; also the demux select encoding {sel1,sel0}
  typedef logic [SELW-1:0] ch_idx_t;
endpackage

// File: rtl/rr_arbiter_4.sv
// Round-robin grant finder: first requesting channel at or after ptr, mod 4.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether a grant is consumed.
module rr_arbiter_4
  import mux_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  ch_idx_t        ptr,
  output ch_idx_t        grant,
  output logic           grant_valid
);

  ch_idx_t idx;

  // Walk the search order from the far end back so the nearest request to ptr wins
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = ptr;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = ptr + ch_idx_t'(k);
      if (req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Merges 4 valid/ready channels into one registered stream, round-robin fair.
// Latency: one cycle from input accept to out_valid/out_data/out_sel.
// Backpressure: out_ready low with a held word stalls; all in_ready drop to 0.
module mux_arbiter
  import mux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic [SELW-1:0]   out_sel,
  input  logic              out_ready
);

  ch_idx_t ptr;
  ch_idx_t grant;
  logic    grant_valid;
  logic    load;

  // Output slot is free this cycle if empty or being drained downstream
  assign load = !out_valid || out_ready;

  rr_arbiter_4 u_arb (
    .req         (in_valid),
    .ptr         (ptr),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Accept only the granted channel, and never while held in reset
  always_comb begin
    in_ready = '0;
    if (rst_n && load && grant_valid) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Output register and fairness pointer; pointer moves past each winner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(grant)*DW +: DW];
        out_sel   <= grant;
        ptr       <= grant + ch_idx_t'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: reference model plus directed vectors.
// Latency: outputs checked on the negative edge after each loading edge.
// Backpressure: stalls driven via out_ready; demux loop-back scoreboard per channel.
module tb_mux_arbiter;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          out_ready;

  int total = 0;
  int bad   = 0;

  mux_arbiter #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // First requesting channel scanning ptr, ptr+1, ... mod 4; -1 if none
  function automatic int find_grant(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4] === 1'b1) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Reference model state
  bit          started = 1'b0;
  logic        mv = 1'b0;
  logic [7:0]  md = 8'h00;
  int          ms = 0;
  int          mp = 0;
  logic [7:0]  src_q[4][$];

  // Model update on each rising edge from the same sampled inputs
  always @(posedge clk) begin : model
    int g;
    if (rst_n === 1'b0) begin
      started = 1'b1;
      mv = 1'b0; md = 8'h00; ms = 0; mp = 0;
    end else if (started && (!mv || out_ready)) begin
      g = find_grant(in_valid, mp);
      if (g >= 0) begin
        mv = 1'b1;
        md = in_data[g*DW +: DW];
        ms = g;
        mp = (g + 1) % 4;
      end else begin
        mv = 1'b0;
      end
    end
  end

  // Every-cycle compare plus demux loop-back scoreboard
  always @(negedge clk) begin : compare
    logic [3:0] er;
    int g;
    if (started) begin
      g  = find_grant(in_valid, mp);
      er = 4'b0000;
      if (rst_n && (!mv || out_ready) && g >= 0) er[g] = 1'b1;
      chk("in_ready", {28'd0, in_ready}, {28'd0, er});
      chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
      if (mv) begin
        chk("out_data", {24'd0, out_data}, {24'd0, md});
        chk("out_sel", {30'd0, out_sel}, ms);
      end
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) src_q[i].delete();
      end else begin
        if (out_valid && out_ready) begin
          if (src_q[out_sel].size() == 0) begin
            total++; bad++;
            $display("FAIL loopback_empty: demux ch %0d got %0h want none", out_sel, out_data);
          end else begin
            chk("loopback", {24'd0, out_data}, {24'd0, src_q[out_sel].pop_front()});
          end
        end
        for (int i = 0; i < 4; i++)
          if (in_valid[i] && er[i]) src_q[i].push_back(in_data[i*DW +: DW]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(logic [7:0] d0, logic [7:0] d1, logic [7:0] d2, logic [7:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  logic [3:0] tv[12] = '{4'b0011, 4'b0011, 4'b1100, 4'b0101, 4'b1111, 4'b1111,
                         4'b0110, 4'b1000, 4'b0000, 4'b1001, 4'b1111, 4'b0010};
  logic       tr[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                         1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [5:0] seq[4] = '{6'd0, 6'd0, 6'd0, 6'd0};
  logic [3:0] acc;
  logic [7:0] exp_d[5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

  initial begin
    rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    step(); step();
    @(negedge clk);
    chk("rst_in_ready", {28'd0, in_ready}, 32'h0);
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
    chk("rst_out_data", {24'd0, out_data}, 32'h0);
    chk("rst_out_sel", {30'd0, out_sel}, 32'h0);

    // All four valid, free-flowing output: strict rotation
    rst_n = 1'b1;
    set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rot_sel", {30'd0, out_sel}, i % 4);
      chk("rot_data", {24'd0, out_data}, {24'd0, exp_d[i]});
    end

    // Lone channel 2 (ptr now 1)
    in_valid = 4'b0100; set_data(8'h00, 8'h00, 8'h5C, 8'h00);
    @(negedge clk);
    chk("ch2_in_ready", {28'd0, in_ready}, 32'h4);
    step();
    chk("ch2_sel", {30'd0, out_sel}, 32'h2);
    chk("ch2_data", {24'd0, out_data}, 32'h5C);
    in_valid = 4'b0000;
    step();
    chk("idle_valid", {31'd0, out_valid}, 32'h0);
    chk("idle_hold_data", {24'd0, out_data}, 32'h5C);

    // ptr = 3 with channels 0 and 3 requesting: wrap-around
    in_valid = 4'b1001; set_data(8'h10, 8'h00, 8'h00, 8'h13);
    step();
    chk("wrap_first", {30'd0, out_sel}, 32'h3);
    step();
    chk("wrap_second", {30'd0, out_sel}, 32'h0);

    // Stall three cycles; valids change underneath the held word
    in_valid = 4'b1111; set_data(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    step();
    chk("pre_stall", {24'd0, out_data}, 32'hB1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) in_valid = 4'b1000;
      @(negedge clk);
      chk("stall_rdy", {28'd0, in_ready}, 32'h0);
      step();
      chk("stall_data", {24'd0, out_data}, 32'hB1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("unstall_rdy", {28'd0, in_ready}, 32'h8);
    step();
    chk("unstall_data", {24'd0, out_data}, 32'hB3);

    // Reset during a stall discards the held word; search restarts at 0
    in_valid = 4'b0001; set_data(8'h77, 8'h00, 8'h00, 8'h00);
    step();
    out_ready = 1'b0; in_valid = 4'b0000;
    step();
    chk("held77", {24'd0, out_data}, 32'h77);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_rdy", {28'd0, in_ready}, 32'h0);
    step();
    chk("rst_mid_valid", {31'd0, out_valid}, 32'h0);
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 4'b1010;
    set_data(8'h00, 8'hC1, 8'h00, 8'hC3);
    @(negedge clk);
    chk("post_rst_rdy", {28'd0, in_ready}, 32'h2);
    step();
    chk("post_rst_sel", {30'd0, out_sel}, 32'h1);
    step();
    chk("post_rst_next", {30'd0, out_sel}, 32'h3);

    // Directed mix of request patterns and stalls for the loop-back check
    for (int j = 0; j < 12; j++) begin
      in_valid  = tv[j];
      out_ready = tr[j];
      set_data({2'd0, seq[0]}, {2'd1, seq[1]}, {2'd2, seq[2]}, {2'd3, seq[3]});
      @(negedge clk);
      acc = in_valid & in_ready;
      step();
      for (int i = 0; i < 4; i++) if (acc[i]) seq[i] = seq[i] + 6'd1;
    end
    in_valid = 4'b0000; out_ready = 1'b1;
    step(); step();
    for (int i = 0; i < 4; i++) chk("drain_empty", src_q[i].size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
